// File: rtl/if_fetch_stage_if.sv
// Instruction ROM bus between the fetch stage and a synchronous ROM.
// master: imem_en/imem_addr out, imem_rdata in; slave: the reverse.
interface if_fetch_stage_if #(
    parameter int IMEM_AW = 12
);
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the fetch PC, drives a 1-cycle ROM, applies
// EX redirects and pipeline_stop, presents pc/pc4/inst/valid to IF/ID.
// Ports: clk, rst_n, pipeline_stop, redirect, redirect_pc,
// imem (ROM bus master), pc_out, pc4_out, inst_out, inst_valid, misalign.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipeline_stop,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    if_fetch_stage_if.master imem,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    output logic        misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] f1_pc_q, f1_pc_d;
    logic        f1_valid_q, f1_valid_d;
    logic        mis_q, mis_d;
    logic        en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fpc_q      <= RESET_PC;
            f1_pc_q    <= 32'h0;
            f1_valid_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            f1_pc_q    <= f1_pc_d;
            f1_valid_q <= f1_valid_d;
            mis_q      <= mis_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        f1_pc_d    = f1_pc_q;
        f1_valid_d = f1_valid_q;
        mis_d      = mis_q;
        en         = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, HOLD: begin
                if (redirect) begin
                    // Kill the in-flight slot; ROM is not read so
                    // the next issue starts cleanly at the target.
                    fpc_d      = {redirect_pc[31:2], 2'b00};
                    f1_valid_d = 1'b0;
                    state_d    = RUN;
                    if (redirect_pc[1:0] != 2'b00) begin
                        mis_d = 1'b1;
                    end
                end else if (pipeline_stop) begin
                    // ROM disabled keeps imem_rdata, so the slot
                    // stays stable while IF/ID is stalled.
                    state_d = HOLD;
                end else begin
                    en         = 1'b1;
                    f1_pc_d    = fpc_q;
                    f1_valid_d = 1'b1;
                    fpc_d      = fpc_q + 32'd4;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem.imem_en   = en;
    assign imem.imem_addr = fpc_q[IMEM_AW+1:2];

    assign pc_out     = f1_valid_q ? f1_pc_q : 32'h0;
    assign pc4_out    = f1_valid_q ? f1_pc_q + 32'd4 : 32'h0;
    assign inst_out   = f1_valid_q ? imem.imem_rdata : NOP;
    assign inst_valid = f1_valid_q;
    assign misalign   = mis_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed stimulus, scoreboard of slots
// expected to be captured by IF/ID, plus direct control checks.
module tb_if_fetch_stage;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipeline_stop;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out, pc4_out, inst_out;
    logic        inst_valid, misalign;

    if_fetch_stage_if #(.IMEM_AW(AW)) bus ();

    if_fetch_stage #(
        .RESET_PC(32'h0000_0100),
        .IMEM_AW (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipeline_stop(pipeline_stop),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem         (bus.master),
        .pc_out       (pc_out),
        .pc4_out      (pc4_out),
        .inst_out     (inst_out),
        .inst_valid   (inst_valid),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    // ROM contents: word 0x40 (byte 0x100) = 0xAAAA0001, then +1 per word
    function automatic logic [31:0] rom(input logic [AW-1:0] w);
        logic [15:0] lo;
        lo = 16'(w) - 16'h003F;
        return {16'hAAAA, lo};
    endfunction

    always_ff @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= rom(bus.imem_addr);
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } slot_t;

    slot_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] romb(input logic [31:0] a);
        return rom(a[AW+1:2]);
    endfunction

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        slot_t s;
        s.pc   = pc;
        s.inst = inst;
        exp_q.push_back(s);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: IF/ID captures the slot when valid and not stalled
    always @(negedge clk) begin
        if (rst_n === 1'b1 && inst_valid === 1'b1 && pipeline_stop === 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL slot_unexpected: got pc %h inst %h want none",
                         pc_out, inst_out);
            end else begin
                slot_t s;
                s = exp_q.pop_front();
                if (pc_out !== s.pc || pc4_out !== s.pc + 32'd4 ||
                    inst_out !== s.inst) begin
                    n_bad++;
                    $display("FAIL slot: got pc %h pc4 %h inst %h want pc %h pc4 %h inst %h",
                             pc_out, pc4_out, inst_out, s.pc, s.pc + 32'd4, s.inst);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_en"}, 32'(bus.imem_en), 32'd0);
        chk({tag, "_addr"}, 32'(bus.imem_addr), 32'h40);
        chk({tag, "_pc"}, pc_out, 32'h0);
        chk({tag, "_pc4"}, pc4_out, 32'h0);
        chk({tag, "_inst"}, inst_out, 32'h13);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_mis"}, 32'(misalign), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        pipeline_stop = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        chk_reset("rst");
        push(32'h100, 32'hAAAA_0001);
        push(32'h104, 32'hAAAA_0002);
        push(32'h108, 32'hAAAA_0003);
        push(32'h10C, 32'hAAAA_0004);
        rst_n = 1'b1;
        mid();
        chk("boot_en", 32'(bus.imem_en), 32'd0);
        cyc();
        mid();
        chk("issue_en", 32'(bus.imem_en), 32'd1);
        chk("issue_addr", 32'(bus.imem_addr), 32'h40);
        cyc();
        cyc();
        cyc();
        pipeline_stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("hold_pc", pc_out, 32'h108);
            chk("hold_inst", inst_out, 32'hAAAA_0003);
            chk("hold_en", 32'(bus.imem_en), 32'd0);
            cyc();
        end
        pipeline_stop = 1'b0;
        mid();
        chk("unhold_en", 32'(bus.imem_en), 32'd1);
        chk("unhold_addr", 32'(bus.imem_addr), 32'h43);
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        push(32'h200, romb(32'h200));
        mid();
        chk("redir_en", 32'(bus.imem_en), 32'd0);
        cyc();
        redirect = 1'b0;
        mid();
        chk("bubble_valid", 32'(inst_valid), 32'd0);
        chk("bubble_inst", inst_out, 32'h13);
        chk("bubble_pc", pc_out, 32'h0);
        chk("bubble_addr", 32'(bus.imem_addr), 32'h80);
        cyc();
        cyc();
        pipeline_stop = 1'b1;
        mid();
        chk("stop2_en", 32'(bus.imem_en), 32'd0);
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        push(32'h300, romb(32'h300));
        push(32'h304, romb(32'h304));
        mid();
        chk("hold2_pc", pc_out, 32'h204);
        cyc();
        redirect      = 1'b0;
        pipeline_stop = 1'b0;
        mid();
        chk("hr_valid", 32'(inst_valid), 32'd0);
        chk("hr_addr", 32'(bus.imem_addr), 32'hC0);
        chk("hr_en", 32'(bus.imem_en), 32'd1);
        cyc();
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h202;
        push(32'h200, romb(32'h200));
        push(32'h204, romb(32'h204));
        mid();
        cyc();
        redirect = 1'b0;
        mid();
        chk("mis_set", 32'(misalign), 32'd1);
        chk("mis_valid", 32'(inst_valid), 32'd0);
        chk("mis_addr", 32'(bus.imem_addr), 32'h80);
        cyc();
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        mid();
        cyc();
        redirect_pc = 32'h500;
        mid();
        chk("b2b_valid", 32'(inst_valid), 32'd0);
        cyc();
        redirect = 1'b0;
        push(32'h500, romb(32'h500));
        push(32'h504, romb(32'h504));
        mid();
        chk("b2b_valid2", 32'(inst_valid), 32'd0);
        chk("b2b_addr", 32'(bus.imem_addr), 32'h140);
        cyc();
        mid();
        chk("mis_sticky", 32'(misalign), 32'd1);
        cyc();
        mid();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        push(32'h100, 32'hAAAA_0001);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        mid();
        chk("reboot_en", 32'(bus.imem_en), 32'd0);
        chk("reboot_valid", 32'(inst_valid), 32'd0);
        cyc();
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        push(32'hFFFF_FFFC, romb(32'hFFFF_FFFC));
        push(32'h0, romb(32'h0));
        mid();
        cyc();
        redirect = 1'b0;
        mid();
        chk("wrap_bubble", 32'(inst_valid), 32'd0);
        cyc();
        mid();
        chk("wrap_pc4", pc4_out, 32'h0);
        chk("wrap_mis", 32'(misalign), 32'd0);
        cyc();
        cyc();
        pipeline_stop = 1'b1;
        repeat (2) cyc();
        chk("queue_left", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
